// File: rtl/n2r_pkg.sv
// rtl/n2r_pkg.sv - shared state encoding and geometry helpers for the n2r scheduler
package n2r_pkg;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FILL  = 3'd1,
        LOAD  = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } state_t;

    // Index width that stays at least one bit for degenerate sizes
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    function automatic int num_cores_for_col(input int col);
        case (col)
            2754:    return 9;
            256:     return 8;
            200:     return 5;
            64:      return 4;
            default: return 2;
        endcase
    endfunction

    function automatic int calc_slice_rows(input int block_size, input int num_cores);
        return block_size * num_cores;
    endfunction

    function automatic int calc_chunks(input int col, input int block_size);
        return col / block_size;
    endfunction

    function automatic int calc_slices(input int row, input int block_size, input int num_cores);
        return row / (block_size * num_cores);
    endfunction

endpackage

// File: rtl/n2r_slice_sched_if.sv
// rtl/n2r_slice_sched_if.sv - row source, row RAM, slice register and core-side signals
interface n2r_slice_sched_if #(
    parameter int ROW        = 8,
    parameter int COL        = 4,
    parameter int BLOCK_SIZE = 2,
    parameter int NUM_CORES  = 2
) ();
    import n2r_pkg::*;

    localparam int AW = idx_w(ROW);
    localparam int SW = idx_w(calc_slice_rows(BLOCK_SIZE, NUM_CORES));
    localparam int CW = idx_w(calc_chunks(COL, BLOCK_SIZE));

    logic          start;
    logic          in_valid;
    logic          in_ready;
    logic          ram_we;
    logic [AW-1:0] ram_waddr;
    logic          ram_re;
    logic [AW-1:0] ram_raddr;
    logic          slice_we;
    logic [SW-1:0] slice_idx;
    logic [CW-1:0] chunk_idx;
    logic          out_valid;
    logic          out_ready;
    logic          out_last;
    logic          frame_done;

    modport master (
        input  start, in_valid, out_ready,
        output in_ready, ram_we, ram_waddr, ram_re, ram_raddr,
               slice_we, slice_idx, chunk_idx, out_valid, out_last, frame_done
    );

    modport slave (
        output start, in_valid, out_ready,
        input  in_ready, ram_we, ram_waddr, ram_re, ram_raddr,
               slice_we, slice_idx, chunk_idx, out_valid, out_last, frame_done
    );

endinterface

// File: rtl/n2r_addr_cnt.sv
// rtl/n2r_addr_cnt.sv - stepping counter with clear, terminal flag and hold at terminal
module n2r_addr_cnt #(
    parameter int WIDTH = 3,
    parameter int STEP  = 1,
    parameter int LAST  = 7
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             en,
    output logic [WIDTH-1:0] count,
    output logic             tc
);

    assign tc = (count == WIDTH'(LAST));

    // Holding at the terminal value keeps every address below its bound
    always_ff @(posedge clk) begin
        if (!rst_n || clr) begin
            count <= '0;
        end else if (en && !tc) begin
            count <= count + WIDTH'(STEP);
        end
    end

endmodule

// File: rtl/n2r_slice_sched.sv
// rtl/n2r_slice_sched.sv - fills the row RAM, replays it slice by slice and hands chunks to the cores
module n2r_slice_sched
    import n2r_pkg::*;
#(
    parameter int ROW        = 8,
    parameter int COL        = 4,
    parameter int BLOCK_SIZE = 2,
    parameter int NUM_CORES  = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    n2r_slice_sched_if.master  bus
);

    localparam int SR = calc_slice_rows(BLOCK_SIZE, NUM_CORES);
    localparam int CH = calc_chunks(COL, BLOCK_SIZE);
    localparam int AW = idx_w(ROW);
    localparam int SW = idx_w(SR);
    localparam int CW = idx_w(CH);
    localparam int LW = idx_w(SR + 1);

    if ((ROW % SR) != 0 || (COL % BLOCK_SIZE) != 0) begin : g_bad_geometry
        $error("n2r_slice_sched: ROW must be a multiple of BLOCK_SIZE*NUM_CORES and COL of BLOCK_SIZE");
    end

    state_t        state;
    logic          in_ready_q;
    logic          out_valid_q;
    logic          frame_done_q;
    logic          in_hs;
    logic          out_hs;
    logic [AW-1:0] wr_cnt;
    logic [AW-1:0] base_cnt;
    logic [LW-1:0] ld_cnt;
    logic [CW-1:0] ch_cnt;
    logic          wr_tc;
    logic          base_tc;
    logic          ld_tc;
    logic          ch_tc;

    assign in_hs  = (state == FILL) && bus.in_valid && in_ready_q;
    assign out_hs = out_valid_q && bus.out_ready;

    n2r_addr_cnt #(.WIDTH(AW), .STEP(1), .LAST(ROW - 1)) u_wr_cnt (
        .clk(clk), .rst_n(rst_n), .clr(state == IDLE), .en(in_hs),
        .count(wr_cnt), .tc(wr_tc)
    );

    // Load index runs one past the slice so the final RAM read lands in the slice register
    n2r_addr_cnt #(.WIDTH(LW), .STEP(1), .LAST(SR)) u_ld_cnt (
        .clk(clk), .rst_n(rst_n), .clr((state != LOAD) || ld_tc), .en(state == LOAD),
        .count(ld_cnt), .tc(ld_tc)
    );

    n2r_addr_cnt #(.WIDTH(CW), .STEP(1), .LAST(CH - 1)) u_ch_cnt (
        .clk(clk), .rst_n(rst_n), .clr((state != DRAIN) || (out_hs && ch_tc)), .en(out_hs),
        .count(ch_cnt), .tc(ch_tc)
    );

    n2r_addr_cnt #(.WIDTH(AW), .STEP(SR), .LAST(ROW - SR)) u_base_cnt (
        .clk(clk), .rst_n(rst_n), .clr(state == IDLE), .en(out_hs && ch_tc),
        .count(base_cnt), .tc(base_tc)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_ready_q   <= 1'b0;
            out_valid_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        state      <= FILL;
                        in_ready_q <= 1'b1;
                    end
                end
                FILL: begin
                    if (in_hs && wr_tc) begin
                        state      <= LOAD;
                        in_ready_q <= 1'b0;
                    end
                end
                LOAD: begin
                    if (ld_tc) begin
                        state       <= DRAIN;
                        out_valid_q <= 1'b1;
                    end
                end
                DRAIN: begin
                    if (out_hs && ch_tc) begin
                        out_valid_q <= 1'b0;
                        if (base_tc) begin
                            state        <= DONE;
                            frame_done_q <= 1'b1;
                        end else begin
                            state <= LOAD;
                        end
                    end
                end
                DONE: state <= IDLE;
                default: begin
                    state       <= IDLE;
                    in_ready_q  <= 1'b0;
                    out_valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign bus.in_ready   = in_ready_q;
    assign bus.ram_we     = in_hs;
    assign bus.ram_waddr  = in_hs ? wr_cnt : '0;
    assign bus.ram_re     = (state == LOAD) && !ld_tc;
    assign bus.ram_raddr  = bus.ram_re ? base_cnt + AW'(ld_cnt) : '0;
    assign bus.slice_we   = (state == LOAD) && (ld_cnt != '0);
    assign bus.slice_idx  = bus.slice_we ? SW'(ld_cnt - LW'(1)) : '0;
    assign bus.chunk_idx  = ch_cnt;
    assign bus.out_valid  = out_valid_q;
    assign bus.out_last   = out_valid_q && ch_tc;
    assign bus.frame_done = frame_done_q;

endmodule

// File: tb/tb_n2r_slice_sched.sv
// tb/tb_n2r_slice_sched.sv - scoreboard bench for n2r_slice_sched with random handshakes
module tb_n2r_slice_sched;

    localparam int ROW = 8;
    localparam int COL = 4;
    localparam int BS  = 2;
    localparam int NC  = 2;
    localparam int SR  = BS * NC;
    localparam int CH  = COL / BS;
    localparam int SL  = ROW / SR;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    n2r_slice_sched_if #(.ROW(ROW), .COL(COL), .BLOCK_SIZE(BS), .NUM_CORES(NC)) bus ();

    n2r_slice_sched #(.ROW(ROW), .COL(COL), .BLOCK_SIZE(BS), .NUM_CORES(NC)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int exp_wr[$];
    int exp_rd[$];
    int exp_sl[$];
    int exp_ch[$];
    int exp_done = 0;
    int fill_hs = 0;
    int ov_cnt = 0;
    int st_cyc = 0;
    int done_cyc = 0;
    int in_mode = 3;
    int ready_mode = 2;
    int prev_hold = 0;
    bit mon_en = 0;
    bit pend_load = 0;
    bit pend_done = 0;
    bit done_seen = 0;
    bit prev_re = 0;
    bit prev_fd = 0;
    bit prev_stall = 0;
    bit hs_in;
    int e;

    task automatic chk(input string nm, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0d required=%0d (cycle %0d)", nm, act, req, cyc);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #1;
        case (in_mode)
            0:       bus.in_valid = 1'b1;
            1:       bus.in_valid = !bus.in_valid;
            2:       bus.in_valid = 1'($urandom_range(0, 1));
            default: bus.in_valid = 1'b0;
        endcase
        case (ready_mode)
            0:       bus.out_ready = 1'b1;
            1:       bus.out_ready = ($urandom_range(0, 2) != 0);
            default: ;
        endcase
    end

    // Expected streams come straight from the frame geometry, independent of stall timing
    task automatic push_model();
        for (int a = 0; a < ROW; a++) exp_wr.push_back(a);
        for (int s = 0; s < SL; s++) begin
            for (int k = 0; k < SR; k++) begin
                exp_rd.push_back(s * SR + k);
                exp_sl.push_back(k);
            end
            for (int c = 0; c < CH; c++)
                exp_ch.push_back(c * 4 + ((c == CH - 1) ? 2 : 0) + ((c == CH - 1 && s == SL - 1) ? 1 : 0));
        end
        exp_done++;
    endtask

    always @(negedge clk) begin
        if (rst_n && mon_en) begin
            hs_in = bus.in_valid && bus.in_ready;
            if (pend_load) begin
                chk("load_one_cycle_after_hs", int'(bus.ram_re), 1);
                pend_load = 0;
            end
            if (pend_done) begin
                chk("done_after_last_chunk", int'(bus.frame_done), 1);
                pend_done = 0;
            end
            if (ov_cnt > 0) begin
                ov_cnt--;
                if (ov_cnt == 0) chk("first_read_to_valid", int'(bus.out_valid), 1);
            end
            if (bus.ram_re && !prev_re) ov_cnt = SR + 1;
            if (prev_stall)
                chk("stall_hold", int'({bus.out_valid, bus.chunk_idx, bus.out_last}), prev_hold);
            if (bus.ram_we || hs_in) chk("we_only_on_hs", int'(bus.ram_we), int'(hs_in));
            if (bus.ram_we) begin
                chk("wr_expected", int'(exp_wr.size() > 0), 1);
                if (exp_wr.size() > 0) chk("ram_waddr", int'(bus.ram_waddr), exp_wr.pop_front());
            end
            if (hs_in) begin
                fill_hs++;
                if (fill_hs == ROW) begin
                    pend_load = 1;
                    fill_hs = 0;
                end
            end
            if (bus.ram_re) begin
                chk("rd_expected", int'(exp_rd.size() > 0), 1);
                if (exp_rd.size() > 0) chk("ram_raddr", int'(bus.ram_raddr), exp_rd.pop_front());
            end
            if (bus.slice_we) begin
                chk("slice_we_after_read", int'(prev_re), 1);
                chk("sl_expected", int'(exp_sl.size() > 0), 1);
                if (exp_sl.size() > 0) chk("slice_idx", int'(bus.slice_idx), exp_sl.pop_front());
            end
            if (bus.out_valid && bus.out_ready) begin
                chk("ch_expected", int'(exp_ch.size() > 0), 1);
                if (exp_ch.size() > 0) begin
                    e = exp_ch.pop_front();
                    chk("chunk_idx_last", int'({bus.chunk_idx, bus.out_last}), e >> 1);
                    if ((e & 3) == 2) pend_load = 1;
                    if ((e & 1) == 1) pend_done = 1;
                end
            end
            if (bus.frame_done) begin
                chk("done_single_pulse", int'(prev_fd), 0);
                chk("done_expected", int'(exp_done > 0), 1);
                if (exp_done > 0) exp_done--;
                done_seen = 1;
                done_cyc = cyc;
            end
            if (bus.in_valid && bus.out_valid)
                chk("in_valid_ignored_in_drain", int'({bus.in_ready, bus.ram_we}), 0);
            prev_re    = bus.ram_re;
            prev_fd    = bus.frame_done;
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_hold  = int'({bus.out_valid, bus.chunk_idx, bus.out_last});
        end
    end

    task automatic chk_all_zero(input string nm);
        chk(nm, int'({bus.in_ready, bus.ram_we, bus.ram_waddr, bus.ram_re, bus.ram_raddr, bus.slice_we,
                      bus.slice_idx, bus.chunk_idx, bus.out_valid, bus.out_last, bus.frame_done}), 0);
    endtask

    task automatic start_frame();
        push_model();
        fill_hs = 0;
        done_seen = 0;
        @(posedge clk); #1;
        bus.start = 1'b1;
        st_cyc = cyc;
        @(posedge clk); #1;
        bus.start = 1'b0;
        chk("start_to_in_ready", int'(bus.in_ready), 1);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done_seen && n < 400) begin
            @(posedge clk);
            n++;
        end
        chk("frame_done_within_bound", int'(done_seen), 1);
        chk("queues_drained", exp_wr.size() + exp_rd.size() + exp_sl.size() + exp_ch.size() + exp_done, 0);
    endtask

    task automatic wait_out_valid(input string nm);
        int n = 0;
        @(posedge clk); #1;
        while (!bus.out_valid && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk(nm, int'(bus.out_valid), 1);
    endtask

    task automatic bp_ctrl();
        wait_out_valid("bp_chunk0_valid");
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            chk("bp_chunk1_held", int'({bus.out_valid, bus.chunk_idx, bus.out_last}), 7);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp_release_load_base4", int'({bus.ram_re, bus.ram_raddr}), 12);
        ready_mode = 0;
    endtask

    initial begin
        int n;
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk_all_zero("reset_outputs");
        rst_n = 1'b1;
        mon_en = 1;

        // basic frame, no stalls
        in_mode = 0;
        ready_mode = 0;
        start_frame();
        wait_done();
        chk("frame_length", done_cyc - st_cyc + 1, 1 + ROW + SL * (SR + 1 + CH) + 1);

        // upstream gaps
        in_mode = 1;
        start_frame();
        wait_done();

        // backpressure on slice 0 chunk 1
        in_mode = 0;
        ready_mode = 2;
        bus.out_ready = 1'b0;
        fork
            begin start_frame(); wait_done(); end
            bp_ctrl();
        join

        // reset during LOAD of slice 1
        ready_mode = 0;
        start_frame();
        n = 0;
        while (!(bus.ram_re && bus.ram_raddr == 3'd4) && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        chk("reached_slice1_load", int'(bus.ram_re && bus.ram_raddr == 3'd4), 1);
        rst_n = 1'b0;
        mon_en = 0;
        @(posedge clk); #1;
        chk_all_zero("reset_mid_frame_outputs");
        exp_wr.delete(); exp_rd.delete(); exp_sl.delete(); exp_ch.delete();
        exp_done = 0; pend_load = 0; pend_done = 0; ov_cnt = 0; fill_hs = 0;
        prev_re = 0; prev_fd = 0; prev_stall = 0;
        @(posedge clk); #1;
        chk_all_zero("reset_held_outputs");
        rst_n = 1'b1;
        mon_en = 1;
        start_frame();
        wait_done();

        // stray start during DRAIN, random in_valid/out_ready
        in_mode = 2;
        ready_mode = 1;
        fork
            begin start_frame(); wait_done(); end
            begin
                wait_out_valid("drain_seen_for_stray_start");
                bus.start = 1'b1;
                @(posedge clk); #1;
                bus.start = 1'b0;
            end
        join
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("no_frame_from_stray_start", int'(bus.in_ready), 0);
        end

        for (int f = 0; f < 4; f++) begin
            start_frame();
            wait_done();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
